mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares a single memory port between the fetch stage (instruction reads) and the MEM stage (data reads/writes). Only one transaction is in flight at a time. Data wins by default; a starvation limit guarantees fetch progress. A kill input drops a stale fetch response after a late branch redirect. The block sits between the pipeline stages and the memory macro and sequences every memory access the core makes.

## Interface
Parameters:
- MEM_LATENCY, 1: cycles from memory issue to m_rdata valid; must be >= 1.
- STARVE_LIMIT, 4: consecutive data grants with i_req pending before fetch is forced; must be >= 1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- i_req  in  1  fetch read request; held stable until i_ready.
- i_addr  in  32  fetch address.
- i_kill  in  1  discard the in-flight fetch response.
- i_ready  out  1  fetch request accepted this cycle.
- i_rvalid  out  1  fetch data valid.
- i_rdata  out  32  fetch data.
- d_req  in  1  data request; held stable until d_ready.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  32  data address.
- d_wdata  in  32  write data.
- d_wbe  in  4  write byte enables.
- d_ready  out  1  data request accepted this cycle.
- d_rvalid  out  1  data completion: read data, or write ack.
- d_rdata  out  32  read data; 0 on write ack.
- m_en  out  1  memory access strobe.
- m_we  out  1  memory write.
- m_addr  out  32  memory address.
- m_wdata  out  32  memory write data.
- m_wbe  out  4  memory byte enables; 4'b0000 on reads.
- m_rdata  in  32  memory read data, valid MEM_LATENCY cycles after m_en.
- busy  out  1  transaction in flight.

## Operation
- FSM states: IDLE, BUSY.
  - IDLE: port is free.
  - BUSY: registers owner (INST/DATA), kill flag, and remaining-count cnt.
- Port is free when the state is IDLE, or when it is BUSY with cnt==1 (the completion cycle).
- Arbitration when free, combinational:
  - Only one requester: it wins.
  - Both requesting: DATA wins, unless starve_cnt == STARVE_LIMIT, in which case INST wins.
- Grant cycle:
  - Winner's ready = 1.
  - m_en = 1; m_* driven combinationally from the winner's inputs.
  - Next state BUSY, cnt <= MEM_LATENCY, owner latched, kill flag <= (owner INST & i_kill).
- While BUSY:
  - cnt decrements each cycle.
  - i_kill = 1 sets the kill flag if owner is INST.
  - d_* and i_* requests are not accepted.
- Completion cycle (cnt==1):
  - Owner's rvalid = 1, and its rdata = m_rdata.
  - Exceptions: i_rvalid is suppressed if the kill flag is set or i_kill = 1 this cycle; for DATA writes, d_rdata = 0.
  - A new grant may occur in the same cycle. Otherwise the state returns to IDLE.
- starve_cnt (width covering STARVE_LIMIT):
  - +1 on a DATA grant while i_req = 1.
  - Cleared on an INST grant, or in any cycle with i_req = 0.
  - Saturates at STARVE_LIMIT.
- Reset: all outputs 0, state IDLE, starve_cnt 0. An in-flight transaction is abandoned with no rvalid.

## Timing
- Accept at cycle t, then rvalid at t+MEM_LATENCY.
- Peak throughput is one transaction per MEM_LATENCY cycles (1/cycle at latency 1).
- ready/rvalid are single-cycle pulses and never asserted for an idle requester.
- When the port is not granting, m_en = 0 and m_* = 0.
- i_kill in the grant cycle kills the transaction just accepted.

## Structure
- Shared package mem_arb_pkg holds:
  - State encoding localparams ST_IDLE/ST_BUSY.
  - Owner encoding OWN_INST/OWN_DATA.
  - Address/data width constants (32).
- Single module, no sub-modules. The latency counter is inline.

## Test plan
- Single fetch, MEM_LATENCY=2, i_addr=0x100, m_rdata=0xDEADBEEF at t+2 -> i_ready at t, i_rvalid with 0xDEADBEEF at t+2, busy high for t+1..t+2.
- Simultaneous i_req and d_req read, STARVE_LIMIT=4, d_req held for 6 transactions -> 4 data grants, then 1 fetch grant, then data resumes; starve_cnt clears.
- Data write, d_addr=0x40, d_wbe=4'b0011 -> m_we=1, m_wbe=4'b0011 in the grant cycle; d_rvalid=1 with d_rdata=0 MEM_LATENCY later.
- i_kill pulsed one cycle after a fetch grant (MEM_LATENCY=3) -> no i_rvalid; a d_req pending at completion is granted in the completion cycle.
- Back-to-back fetches, MEM_LATENCY=1 -> i_ready every cycle; i_rvalid each following cycle carries the matching data.
- rst asserted while BUSY -> next cycle all outputs 0, no rvalid; a request after reset is granted immediately.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter.
//   state_t : arbiter FSM encoding (ST_IDLE, ST_BUSY)
//   owner_t : which requester owns the in-flight transaction (OWN_INST, OWN_DATA)
//   ADDR_W / DATA_W : memory address and data widths
package mem_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and the
// MEM stage. One transaction in flight at a time; data has priority, but after
// STARVE_LIMIT consecutive data grants with a fetch waiting, fetch is forced.
// i_kill drops the response of an in-flight fetch.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   i_req/i_addr/i_kill           fetch request, address, response kill
//   i_ready/i_rvalid/i_rdata      fetch accept pulse, response valid, data
//   d_req/d_we/d_addr/d_wdata/d_wbe  data request and write payload
//   d_ready/d_rvalid/d_rdata      data accept pulse, completion, read data
//   m_en/m_we/m_addr/m_wdata/m_wbe   memory command (combinational, grant cycle)
//   m_rdata                       memory read data, MEM_LATENCY after m_en
//   busy                          transaction in flight
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_kill,
    output logic              i_ready,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_wbe,
    output logic              d_ready,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic [3:0]        m_wbe,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy
);

    localparam int CNT_W = (MEM_LATENCY  < 1) ? 1 : $clog2(MEM_LATENCY + 1);
    localparam int SC_W  = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    state_t             state_reg,  state_next;
    owner_t             owner_reg,  owner_next;
    logic               kill_reg,   kill_next;
    logic               we_reg,     we_next;
    logic [CNT_W-1:0]   cnt_reg,    cnt_next;
    logic [SC_W-1:0]    starve_reg, starve_next;

    logic completing;
    logic port_free;
    logic starved;
    logic grant_inst;
    logic grant_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            owner_reg  <= OWN_INST;
            kill_reg   <= 1'b0;
            we_reg     <= 1'b0;
            cnt_reg    <= '0;
            starve_reg <= '0;
        end else begin
            state_reg  <= state_next;
            owner_reg  <= owner_next;
            kill_reg   <= kill_next;
            we_reg     <= we_next;
            cnt_reg    <= cnt_next;
            starve_reg <= starve_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        owner_next  = owner_reg;
        kill_next   = kill_reg;
        we_next     = we_reg;
        cnt_next    = cnt_reg;
        starve_next = starve_reg;

        i_ready  = 1'b0;
        i_rvalid = 1'b0;
        i_rdata  = '0;
        d_ready  = 1'b0;
        d_rvalid = 1'b0;
        d_rdata  = '0;
        m_en     = 1'b0;
        m_we     = 1'b0;
        m_addr   = '0;
        m_wdata  = '0;
        m_wbe    = 4'b0000;
        busy     = (state_reg == ST_BUSY);

        // The completion cycle frees the port so a new grant can overlap it.
        completing = (state_reg == ST_BUSY) && (cnt_reg == CNT_W'(1));
        port_free  = (state_reg == ST_IDLE) || completing;
        starved    = (starve_reg == SC_W'(STARVE_LIMIT));
        grant_inst = port_free && i_req && (!d_req || starved);
        grant_data = port_free && d_req && !grant_inst;

        if (state_reg == ST_BUSY) begin
            cnt_next = cnt_reg - CNT_W'(1);
            if (owner_reg == OWN_INST && i_kill) begin
                kill_next = 1'b1;
            end
        end

        if (completing) begin
            state_next = ST_IDLE;
            if (owner_reg == OWN_INST) begin
                // A kill arriving in the completion cycle itself still drops the data.
                if (!kill_reg && !i_kill) begin
                    i_rvalid = 1'b1;
                    i_rdata  = m_rdata;
                end
            end else begin
                d_rvalid = 1'b1;
                d_rdata  = we_reg ? '0 : m_rdata;
            end
        end

        if (grant_inst) begin
            i_ready    = 1'b1;
            m_en       = 1'b1;
            m_addr     = i_addr;
            state_next = ST_BUSY;
            owner_next = OWN_INST;
            cnt_next   = CNT_W'(MEM_LATENCY);
            kill_next  = i_kill;
            we_next    = 1'b0;
        end else if (grant_data) begin
            d_ready    = 1'b1;
            m_en       = 1'b1;
            m_we       = d_we;
            m_addr     = d_addr;
            m_wdata    = d_wdata;
            m_wbe      = d_we ? d_wbe : 4'b0000;
            state_next = ST_BUSY;
            owner_next = OWN_DATA;
            cnt_next   = CNT_W'(MEM_LATENCY);
            kill_next  = 1'b0;
            we_next    = d_we;
        end

        // Starvation counts only data grants that actually bypassed a waiting fetch.
        if (!i_req || grant_inst) begin
            starve_next = '0;
        end else if (grant_data && !starved) begin
            starve_next = starve_reg + SC_W'(1);
        end

        // Reset silences every output immediately, abandoning any transaction.
        if (rst) begin
            i_ready  = 1'b0;
            i_rvalid = 1'b0;
            i_rdata  = '0;
            d_ready  = 1'b0;
            d_rvalid = 1'b0;
            d_rdata  = '0;
            m_en     = 1'b0;
            m_we     = 1'b0;
            m_addr   = '0;
            m_wdata  = '0;
            m_wbe    = 4'b0000;
            busy     = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Table-driven bench for mem_port_arbiter (MEM_LATENCY=2, STARVE_LIMIT=4).
// Each table row is one clock cycle: inputs plus every expected output.
// A small memory model returns md(addr) two cycles after m_en.
module tb_mem_port_arbiter;

    localparam int LAT = 2;
    localparam int SL  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_kill, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [3:0]  d_wbe;
    logic        i_ready, i_rvalid, d_ready, d_rvalid, m_en, m_we, busy;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata, m_rdata;
    logic [3:0]  m_wbe;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LATENCY(LAT), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill),
        .i_ready(i_ready), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wbe(d_wbe),
        .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wbe(m_wbe),
        .m_rdata(m_rdata), .busy(busy)
    );

    function automatic logic [31:0] md(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : ((a ^ 32'hC0DE_0000) + 32'h11);
    endfunction

    // Memory model: data for an address issued at cycle t appears in cycle t+2.
    logic [31:0] pipe0 = 32'h0;
    logic [31:0] pipe1 = 32'h0;
    always @(posedge clk) begin
        pipe0 <= m_en ? md(m_addr) : 32'hBAD0_0000;
        pipe1 <= pipe0;
    end
    assign m_rdata = pipe1;

    typedef struct {
        string       name;
        logic        rst, ir, ik, dr, dwe;
        logic [31:0] ia, da, dwd;
        logic [3:0]  dwbe;
        logic [138:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic add(input string name, input logic r, input logic ir, input logic [31:0] ia,
                       input logic ik, input logic dr, input logic dwe, input logic [31:0] da,
                       input logic [31:0] dwd, input logic [3:0] dwbe,
                       input logic irdy, input logic irv, input logic [31:0] ird,
                       input logic drdy, input logic drv, input logic [31:0] drd,
                       input logic men, input logic mwe, input logic [31:0] maddr,
                       input logic [31:0] mwd, input logic [3:0] mwbe, input logic bsy);
        vec_t v;
        v.name = name; v.rst = r; v.ir = ir; v.ia = ia; v.ik = ik;
        v.dr = dr; v.dwe = dwe; v.da = da; v.dwd = dwd; v.dwbe = dwbe;
        v.exp = {irdy, irv, ird, drdy, drv, drd, men, mwe, maddr, mwd, mwbe, bsy};
        vecs.push_back(v);
    endtask

    task automatic apply(input vec_t v);
        rst = v.rst; i_req = v.ir; i_addr = v.ia; i_kill = v.ik;
        d_req = v.dr; d_we = v.dwe; d_addr = v.da; d_wdata = v.dwd; d_wbe = v.dwbe;
    endtask

    task automatic check(input string name, input logic [138:0] got, input logic [138:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, got, want);
        end
    endtask

    initial begin
        logic [138:0] got;
        int lat;

        //   name       rst ir ia           ik dr dwe da           dwd           wbe   | irdy irv ird              drdy drv drd        men mwe maddr         mwd           mwbe busy
        add("reset",     1, 0, 32'h0,       0, 0, 0, 32'h0,       32'h0,        4'h0,  0, 0, 32'h0,            0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 0);
        add("idle",      0, 0, 32'h0,       0, 0, 0, 32'h0,       32'h0,        4'h0,  0, 0, 32'h0,            0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 0);
        // single fetch
        add("f_grant",   0, 1, 32'h100,     0, 0, 0, 32'h0,       32'h0,        4'h0,  1, 0, 32'h0,            0, 0, 32'h0,        1, 0, 32'h100,      32'h0,        4'h0, 0);
        add("f_busy",    0, 0, 32'h0,       0, 0, 0, 32'h0,       32'h0,        4'h0,  0, 0, 32'h0,            0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 1);
        add("f_done",    0, 0, 32'h0,       0, 0, 0, 32'h0,       32'h0,        4'h0,  0, 1, 32'hDEADBEEF,     0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 1);
        add("f_idle",    0, 0, 32'h0,       0, 0, 0, 32'h0,       32'h0,        4'h0,  0, 0, 32'h0,            0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 0);
        // data write
        add("w_grant",   0, 0, 32'h0,       0, 1, 1, 32'h40,      32'h12345678, 4'h3,  0, 0, 32'h0,            1, 0, 32'h0,        1, 1, 32'h40,       32'h12345678, 4'h3, 0);
        add("w_busy",    0, 0, 32'h0,       0, 0, 0, 32'h0,       32'h0,        4'h0,  0, 0, 32'h0,            0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 1);
        add("w_ack",     0, 0, 32'h0,       0, 0, 0, 32'h0,       32'h0,        4'h0,  0, 0, 32'h0,            0, 1, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 1);
        add("w_idle",    0, 0, 32'h0,       0, 0, 0, 32'h0,       32'h0,        4'h0,  0, 0, 32'h0,            0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 0);
        // kill one cycle after grant; pending data read granted in completion cycle
        add("k_grant",   0, 1, 32'h200,     0, 0, 0, 32'h0,       32'h0,        4'h0,  1, 0, 32'h0,            0, 0, 32'h0,        1, 0, 32'h200,      32'h0,        4'h0, 0);
        add("k_kill",    0, 0, 32'h0,       1, 0, 0, 32'h0,       32'h0,        4'h0,  0, 0, 32'h0,            0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 1);
        add("k_done_dg", 0, 0, 32'h0,       0, 1, 0, 32'h300,     32'h0,        4'h0,  0, 0, 32'h0,            1, 0, 32'h0,        1, 0, 32'h300,      32'h0,        4'h0, 1);
        add("k_dbusy",   0, 0, 32'h0,       0, 0, 0, 32'h0,       32'h0,        4'h0,  0, 0, 32'h0,            0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 1);
        add("k_drd",     0, 0, 32'h0,       0, 0, 0, 32'h0,       32'h0,        4'h0,  0, 0, 32'h0,            0, 1, md(32'h300),  0, 0, 32'h0,        32'h0,        4'h0, 1);
        add("k_idle",    0, 0, 32'h0,       0, 0, 0, 32'h0,       32'h0,        4'h0,  0, 0, 32'h0,            0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 0);
        // kill in the grant cycle
        add("kg_grant",  0, 1, 32'h204,     1, 0, 0, 32'h0,       32'h0,        4'h0,  1, 0, 32'h0,            0, 0, 32'h0,        1, 0, 32'h204,      32'h0,        4'h0, 0);
        add("kg_busy",   0, 0, 32'h0,       0, 0, 0, 32'h0,       32'h0,        4'h0,  0, 0, 32'h0,            0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 1);
        add("kg_done",   0, 0, 32'h0,       0, 0, 0, 32'h0,       32'h0,        4'h0,  0, 0, 32'h0,            0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 1);
        // starvation: fetch 0x400 waits behind four data reads
        add("s_d1",      0, 1, 32'h400,     0, 1, 0, 32'h500,     32'h0,        4'h0,  0, 0, 32'h0,            1, 0, 32'h0,        1, 0, 32'h500,      32'h0,        4'h0, 0);
        add("s_b1",      0, 1, 32'h400,     0, 1, 0, 32'h504,     32'h0,        4'h0,  0, 0, 32'h0,            0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 1);
        add("s_d2",      0, 1, 32'h400,     0, 1, 0, 32'h504,     32'h0,        4'h0,  0, 0, 32'h0,            1, 1, md(32'h500),  1, 0, 32'h504,      32'h0,        4'h0, 1);
        add("s_b2",      0, 1, 32'h400,     0, 1, 0, 32'h508,     32'h0,        4'h0,  0, 0, 32'h0,            0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 1);
        add("s_d3",      0, 1, 32'h400,     0, 1, 0, 32'h508,     32'h0,        4'h0,  0, 0, 32'h0,            1, 1, md(32'h504),  1, 0, 32'h508,      32'h0,        4'h0, 1);
        add("s_b3",      0, 1, 32'h400,     0, 1, 0, 32'h50C,     32'h0,        4'h0,  0, 0, 32'h0,            0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 1);
        add("s_d4",      0, 1, 32'h400,     0, 1, 0, 32'h50C,     32'h0,        4'h0,  0, 0, 32'h0,            1, 1, md(32'h508),  1, 0, 32'h50C,      32'h0,        4'h0, 1);
        add("s_b4",      0, 1, 32'h400,     0, 1, 0, 32'h510,     32'h0,        4'h0,  0, 0, 32'h0,            0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 1);
        add("s_forced",  0, 1, 32'h400,     0, 1, 0, 32'h510,     32'h0,        4'h0,  1, 0, 32'h0,            0, 1, md(32'h50C),  1, 0, 32'h400,      32'h0,        4'h0, 1);
        add("s_fbusy",   0, 0, 32'h0,       0, 1, 0, 32'h510,     32'h0,        4'h0,  0, 0, 32'h0,            0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 1);
        add("s_d5",      0, 0, 32'h0,       0, 1, 0, 32'h510,     32'h0,        4'h0,  0, 1, md(32'h400),      1, 0, 32'h0,        1, 0, 32'h510,      32'h0,        4'h0, 1);
        add("s_b5",      0, 0, 32'h0,       0, 1, 0, 32'h514,     32'h0,        4'h0,  0, 0, 32'h0,            0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 1);
        add("s_d6",      0, 0, 32'h0,       0, 1, 0, 32'h514,     32'h0,        4'h0,  0, 0, 32'h0,            1, 1, md(32'h510),  1, 0, 32'h514,      32'h0,        4'h0, 1);
        add("s_b6",      0, 0, 32'h0,       0, 0, 0, 32'h0,       32'h0,        4'h0,  0, 0, 32'h0,            0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 1);
        add("s_r6",      0, 0, 32'h0,       0, 0, 0, 32'h0,       32'h0,        4'h0,  0, 0, 32'h0,            0, 1, md(32'h514),  0, 0, 32'h0,        32'h0,        4'h0, 1);
        add("s_idle",    0, 0, 32'h0,       0, 0, 0, 32'h0,       32'h0,        4'h0,  0, 0, 32'h0,            0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 0);
        // kill arriving in the completion cycle
        add("kc_grant",  0, 1, 32'h600,     0, 0, 0, 32'h0,       32'h0,        4'h0,  1, 0, 32'h0,            0, 0, 32'h0,        1, 0, 32'h600,      32'h0,        4'h0, 0);
        add("kc_busy",   0, 0, 32'h0,       0, 0, 0, 32'h0,       32'h0,        4'h0,  0, 0, 32'h0,            0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 1);
        add("kc_done",   0, 0, 32'h0,       1, 0, 0, 32'h0,       32'h0,        4'h0,  0, 0, 32'h0,            0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 1);
        add("kc_idle",   0, 0, 32'h0,       0, 0, 0, 32'h0,       32'h0,        4'h0,  0, 0, 32'h0,            0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 0);
        // back-to-back fetches at peak throughput
        add("bb_g1",     0, 1, 32'h700,     0, 0, 0, 32'h0,       32'h0,        4'h0,  1, 0, 32'h0,            0, 0, 32'h0,        1, 0, 32'h700,      32'h0,        4'h0, 0);
        add("bb_b1",     0, 1, 32'h704,     0, 0, 0, 32'h0,       32'h0,        4'h0,  0, 0, 32'h0,            0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 1);
        add("bb_g2",     0, 1, 32'h704,     0, 0, 0, 32'h0,       32'h0,        4'h0,  1, 1, md(32'h700),      0, 0, 32'h0,        1, 0, 32'h704,      32'h0,        4'h0, 1);
        add("bb_b2",     0, 0, 32'h0,       0, 0, 0, 32'h0,       32'h0,        4'h0,  0, 0, 32'h0,            0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 1);
        add("bb_r2",     0, 0, 32'h0,       0, 0, 0, 32'h0,       32'h0,        4'h0,  0, 1, md(32'h704),      0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 1);
        add("bb_idle",   0, 0, 32'h0,       0, 0, 0, 32'h0,       32'h0,        4'h0,  0, 0, 32'h0,            0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 0);
        // reset while busy
        add("rb_grant",  0, 1, 32'h800,     0, 0, 0, 32'h0,       32'h0,        4'h0,  1, 0, 32'h0,            0, 0, 32'h0,        1, 0, 32'h800,      32'h0,        4'h0, 0);
        add("rb_rst",    1, 0, 32'h0,       0, 0, 0, 32'h0,       32'h0,        4'h0,  0, 0, 32'h0,            0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 0);
        add("rb_regr",   0, 0, 32'h0,       0, 1, 0, 32'h900,     32'h0,        4'h0,  0, 0, 32'h0,            1, 0, 32'h0,        1, 0, 32'h900,      32'h0,        4'h0, 0);
        add("rb_busy",   0, 0, 32'h0,       0, 0, 0, 32'h0,       32'h0,        4'h0,  0, 0, 32'h0,            0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 1);
        add("rb_rd",     0, 0, 32'h0,       0, 0, 0, 32'h0,       32'h0,        4'h0,  0, 0, 32'h0,            0, 1, md(32'h900),  0, 0, 32'h0,        32'h0,        4'h0, 1);
        add("rb_idle",   0, 0, 32'h0,       0, 0, 0, 32'h0,       32'h0,        4'h0,  0, 0, 32'h0,            0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 0);

        for (int k = 0; k < vecs.size(); k++) begin
            apply(vecs[k]);
            @(negedge clk);
            got = {i_ready, i_rvalid, i_rdata, d_ready, d_rvalid, d_rdata,
                   m_en, m_we, m_addr, m_wdata, m_wbe, busy};
            check(vecs[k].name, got, vecs[k].exp);
            $display("vec %0d %s: m_en=%0b m_addr=%h i_rv=%0b d_rv=%0b busy=%0b",
                     k, vecs[k].name, m_en, m_addr, i_rvalid, d_rvalid, busy);
            @(posedge clk);
            #1;
        end

        // Latency measured with a bounded wait: read 0xA00, expect rvalid 2 cycles later.
        rst = 1'b0; i_req = 1'b0; i_kill = 1'b0; d_we = 1'b0; d_req = 1'b1; d_addr = 32'hA00;
        @(negedge clk);
        check("lat_ready", {138'd0, d_ready}, {138'd0, 1'b1});
        @(posedge clk);
        #1;
        d_req = 1'b0; d_addr = 32'h0;
        lat = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (d_rvalid) begin
                lat = c;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("lat_cycles", {107'd0, 32'(lat)}, {107'd0, 32'(LAT)});
        check("lat_rdata", {107'd0, d_rdata}, {107'd0, md(32'hA00)});
        $display("latency read: cycles=%0d d_rdata=%h", lat, d_rdata);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
